// File: rtl/regfile_access_router_if.sv
// Register-file access port bundle: one read address plus one write channel.
// The source of a request drives it as master; the router consumes it as slave.
interface regfile_access_router_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] din;
    logic              wr_en;

    modport master (output r_addr, w_addr, din, wr_en);
    modport slave  (input  r_addr, w_addr, din, wr_en);
endinterface

// File: rtl/regfile_access_router.sv
// Ownership mux between the user port and the internal engine in front of the
// 32x8 register file, with registered drop/ownership-change status for debug.
module regfile_access_router #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    busy,
    regfile_access_router_if.slave  usr,
    regfile_access_router_if.slave  internal,
    regfile_access_router_if.master rf,
    output logic                    usr_wr_dropped,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    owner_switch
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ADDR_W-1:0] sel_r_addr;
    logic [ADDR_W-1:0] sel_w_addr;
    logic [DATA_W-1:0] sel_din;
    logic              sel_wr_en;
    logic              busy_q;
    logic              drop_now;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_r_addr = usr.r_addr;
        sel_w_addr = usr.w_addr;
        sel_din    = usr.din;
        sel_wr_en  = usr.wr_en;
        if (busy) begin
            sel_r_addr = internal.r_addr;
            sel_w_addr = internal.w_addr;
            sel_din    = internal.din;
            sel_wr_en  = internal.wr_en;
        end
    end

    // Reset only gates the write strobe; addresses and data keep following the owner.
    assign rf.r_addr = sel_r_addr;
    assign rf.w_addr = sel_w_addr;
    assign rf.din    = sel_din;
    assign rf.wr_en  = sel_wr_en & ~rst;

    assign drop_now = busy & usr.wr_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            usr_wr_dropped <= 1'b0;
            owner_switch   <= 1'b0;
            drop_cnt       <= '0;
            busy_q         <= busy;  // suppresses a false switch on the first cycle out of reset
        end else begin
            usr_wr_dropped <= drop_now;
            owner_switch   <= (busy != busy_q);
            busy_q         <= busy;
            if (drop_now && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_router.sv
// Self-checking bench for regfile_access_router: constant vector table, directed
// multi-cycle sequences, and randomized cycles against a behavioural model.
module tb_regfile_access_router;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic             usr_wr_dropped;
    logic [CNT_W-1:0] drop_cnt;
    logic             owner_switch;

    regfile_access_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) usr_if ();
    regfile_access_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) int_if ();
    regfile_access_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rf_if ();

    regfile_access_router #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .busy           (busy),
        .usr            (usr_if.slave),
        .internal       (int_if.slave),
        .rf             (rf_if.master),
        .usr_wr_dropped (usr_wr_dropped),
        .drop_cnt       (drop_cnt),
        .owner_switch   (owner_switch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the status section.
    bit model_valid = 1'b0;
    bit m_prev_busy;
    bit m_dropped;
    bit m_switch;
    int m_cnt;

    typedef struct {
        logic       busy;
        logic       rst;
        logic [4:0] ur;
        logic [4:0] uw;
        logic [7:0] ud;
        logic       uwe;
        logic [4:0] ir;
        logic [4:0] iw;
        logic [7:0] id;
        logic       iwe;
        logic [4:0] er;
        logic [4:0] ew;
        logic [7:0] ed;
        logic       ewe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input logic r,
                         input logic [4:0] ur, input logic [4:0] uw, input logic [7:0] ud, input logic uwe,
                         input logic [4:0] ir, input logic [4:0] iw, input logic [7:0] id, input logic iwe);
        busy           = b;
        rst            = r;
        usr_if.r_addr  = ur;
        usr_if.w_addr  = uw;
        usr_if.din     = ud;
        usr_if.wr_en   = uwe;
        int_if.r_addr  = ir;
        int_if.w_addr  = iw;
        int_if.din     = id;
        int_if.wr_en   = iwe;
    endtask

    // Expected regfile port derived from the ownership rule.
    task automatic check_mux(input string tag);
        logic [4:0] er, ew;
        logic [7:0] ed;
        logic       ewe;
        er  = busy ? int_if.r_addr : usr_if.r_addr;
        ew  = busy ? int_if.w_addr : usr_if.w_addr;
        ed  = busy ? int_if.din    : usr_if.din;
        ewe = (busy ? int_if.wr_en : usr_if.wr_en) && !rst;
        check({tag, ".r_addr"}, 32'(rf_if.r_addr), 32'(er));
        check({tag, ".w_addr"}, 32'(rf_if.w_addr), 32'(ew));
        check({tag, ".din"},    32'(rf_if.din),    32'(ed));
        check({tag, ".wr_en"},  32'(rf_if.wr_en),  32'(ewe));
    endtask

    // Advance one clock edge, update the model with the inputs held across it,
    // then compare the registered status outputs.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) begin
            m_dropped   = 1'b0;
            m_switch    = 1'b0;
            m_cnt       = 0;
            m_prev_busy = busy;
            model_valid = 1'b1;
        end else begin
            m_dropped   = busy && usr_if.wr_en;
            m_switch    = (busy != m_prev_busy);
            m_prev_busy = busy;
            if (m_dropped) m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
        end
        #1;
        if (model_valid) begin
            check({tag, ".usr_wr_dropped"}, 32'(usr_wr_dropped), 32'(m_dropped));
            check({tag, ".owner_switch"},   32'(owner_switch),   32'(m_switch));
            check({tag, ".drop_cnt"},       32'(drop_cnt),       32'(m_cnt));
        end
    endtask

    task automatic do_reset(input logic b);
        drive(b, 1'b1, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0);
        #1;
        check("reset.wr_en_forced_low", 32'(rf_if.wr_en), 32'd0);
        cycle("reset");
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0, 5'h00, 5'h00, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 5'h01, 5'h02, 8'h33, 1'b1, 5'h1A, 5'h1B, 8'hC4, 1'b1, 5'h1A, 5'h1B, 8'hC4, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 5'h05, 5'h06, 8'h77, 1'b0, 5'h1F, 5'h1E, 8'hAA, 1'b1, 5'h05, 5'h06, 8'h77, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h03, 5'h04, 8'h55, 1'b1, 5'h03, 5'h04, 8'h55, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h03, 5'h04, 8'h55, 1'b1, 5'h11, 5'h12, 8'hFF, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5'h1F, 5'h00, 8'h80, 1'b1, 5'h0A, 5'h0B, 8'h0C, 1'b1, 5'h1F, 5'h00, 8'h80, 1'b1};

        // Reset with the user owning and writing: strobe held low, status cleared.
        do_reset(1'b0);
        check("reset.drop_cnt_zero", 32'(drop_cnt), 32'd0);
        drive(1'b0, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0);
        #1;
        check("post_reset.wr_en_restored", 32'(rf_if.wr_en), 32'd1);
        cycle("post_reset");

        // Constant vector table, one clock edge per row so the status model tracks too.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].busy, vecs[i].rst, vecs[i].ur, vecs[i].uw, vecs[i].ud, vecs[i].uwe,
                  vecs[i].ir, vecs[i].iw, vecs[i].id, vecs[i].iwe);
            #1;
            check($sformatf("vec%0d.r_addr", i), 32'(rf_if.r_addr), 32'(vecs[i].er));
            check($sformatf("vec%0d.w_addr", i), 32'(rf_if.w_addr), 32'(vecs[i].ew));
            check($sformatf("vec%0d.din", i),    32'(rf_if.din),    32'(vecs[i].ed));
            check($sformatf("vec%0d.wr_en", i),  32'(rf_if.wr_en),  32'(vecs[i].ewe));
            cycle($sformatf("vec%0d", i));
        end

        // Three consecutive dropped user writes, then release.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h02, 5'h03, 8'h44, i[0]);
            #1;
            check("drop3.wr_en_internal", 32'(rf_if.wr_en), 32'(i[0]));
            cycle("drop3");
            check("drop3.pulse_high", 32'(usr_wr_dropped), 32'd1);
        end
        check("drop3.count", 32'(drop_cnt), 32'd3);
        drive(1'b0, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b0, 5'h00, 5'h00, 8'h00, 1'b0);
        cycle("drop3_release");
        check("drop3_release.pulse_low", 32'(usr_wr_dropped), 32'd0);
        check("drop3_release.switch", 32'(owner_switch), 32'd1);

        // Internal write while the user owns: ignored, no drop counted.
        drive(1'b0, 1'b0, 5'h04, 5'h05, 8'h66, 1'b0, 5'h07, 5'h08, 8'h99, 1'b1);
        #1;
        check("int_ignored.wr_en", 32'(rf_if.wr_en), 32'd0);
        cycle("int_ignored");
        check("int_ignored.count_held", 32'(drop_cnt), 32'd3);

        // Saturation: 300 dropped writes in a row.
        do_reset(1'b1);
        drive(1'b1, 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0);
        for (int i = 0; i < 300; i++) cycle("sat");
        check("sat.count_255", 32'(drop_cnt), 32'd255);
        cycle("sat_hold");
        check("sat_hold.count_255", 32'(drop_cnt), 32'd255);

        // busy toggling with a steady user write: both pulses together on the rising edge.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(i[0], 1'b0, 5'h11, 5'h12, 8'hFF, 1'b1, 5'h00, 5'h00, 8'h00, 1'b0);
            #1;
            check_mux("toggle");
            cycle("toggle");
        end

        // Randomized traffic with occasional resets and sticky ownership.
        drive(1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 1'b0, 5'h00, 5'h00, 8'h00, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic nb;
            nb = ($urandom_range(0, 3) == 0) ? ~busy : busy;
            drive(nb, ($urandom_range(0, 24) == 0),
                  5'($urandom), 5'($urandom), 8'($urandom), 1'($urandom),
                  5'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
            #1;
            check_mux("rand");
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
